fifo_read_ctrl: RTL and testbench
=================================

Name: fifo_read_ctrl

Overview:
Read-domain controller for the team's asynchronous FIFO. It is the reader counterpart of the write-side memory/controller.
- Owns the read pointer, drives the memory read address and consumes the combinational memory read data.
- Synchronizes the Gray-coded write pointer into the read clock domain and generates empty, almost-empty and fill level.
- Presents data to the consumer through a registered valid/ready output stage (first-word-fall-through).

Parameters:
DATASIZE, 8, data word width
ADDRSIZE, 4, memory address width; depth = 2**ADDRSIZE
AEMPTY_THRESH, 2, rd_almost_empty asserts when rd_level <= this value

Ports:
rd_clk  in  1  read-domain clock
rd_rst_n  in  1  synchronous active-low reset, sampled on rd_clk rising edge
wptr_gray  in  ADDRSIZE+1  Gray write pointer from write domain (asynchronous to rd_clk)
mem_rdata  in  DATASIZE  combinational read data from the memory at rd_addr
rd_addr  out  ADDRSIZE  memory read address = rbin[ADDRSIZE-1:0]
rptr_gray  out  ADDRSIZE+1  registered Gray read pointer, sent to write domain
rd_empty  out  1  registered; no unread word in memory
rd_almost_empty  out  1  registered; rd_level <= AEMPTY_THRESH
rd_level  out  ADDRSIZE+1  words in memory, excluding the output register (pessimistic)
rdata  out  DATASIZE  output data register
rvalid  out  1  rdata holds a valid word
rready  in  1  consumer accepts rdata when rvalid && rready

Behaviour:
- All state changes on rd_clk rising edge. rd_rst_n=0 has priority over all other inputs.
- Reset values: rbin=0, rptr_gray=0, wq1=wq2=0, rd_empty=1, rd_almost_empty=1, rd_level=0, rdata=0, rvalid=0.
- Sync: wq1<=wptr_gray, wq2<=wq1. Only wq2 is used downstream.
- Pop condition: pop = !rd_empty && (!rvalid || rready). This allows one pop per cycle at full throughput.
- On pop: rdata<=mem_rdata, rvalid<=1, rbin<=rbin+1. The pointer is ADDRSIZE+1 bits and wraps modulo 2**(ADDRSIZE+1).
- No pop and rvalid && rready: rvalid<=0, rdata holds its value.
- rbin_next = rbin + pop. rptr_gray <= (rbin_next>>1) ^ rbin_next.
- rd_empty <= (gray(rbin_next) == wq2).
- wbin_s = gray2bin(wq2). rd_level <= (wbin_s - rbin_next) mod 2**(ADDRSIZE+1). rd_almost_empty <= (level_next <= AEMPTY_THRESH).
- Latency: a stable change of wptr_gray 0->1 gives rd_empty=0 after the 3rd rd_clk edge and rvalid=1 after the 4th edge.
- Memory empty, output held: rvalid stays 1 and rdata is stable until rready.
- rready while rvalid=0: no effect.
- Wrap: after 2**ADDRSIZE reads, rd_addr returns to 0 while rbin MSB toggles. Empty is detected only on full Gray equality.
- Reset mid-stream: the pending rvalid word is discarded and pointers return to 0. The write domain must be reset concurrently; this is a system requirement.
- Never pop when rd_empty=1, and never overwrite rdata while rvalid && !rready.

Decomposition:
- Package fifo_pkg: functions bin2gray and gray2bin, parameterized by width, or localparam PTRW = ADDRSIZE+1 passed in. The write side shares the same package.
- Sub-module sync_2ff (parameter WIDTH, ports rd_clk, rd_rst_n, d, q): the two-flop synchronizer, reused by the write side for rptr_gray.

Test Plan:
(All scenarios with DATASIZE=8, ADDRSIZE=4, AEMPTY_THRESH=2; the bench models the memory and the write pointer.)
- Reset: hold rd_rst_n=0 for 3 cycles with wptr_gray=5'h03 -> all outputs at reset values. After release, rd_empty falls after 3 edges.
- Single word: mem[0]=8'hA5, wptr_gray 0->1, rready=0 -> rvalid=1 with rdata=8'hA5 after the 4th edge, held for 10 cycles. rd_empty=1 and rptr_gray=5'h01. Assert rready for one cycle -> rvalid=0 on the next edge.
- Streaming: write 16 words 8'h00..8'h0F (wptr_gray=gray(16)=5'h18), rready=1 -> 16 consecutive rdata values 00..0F, one per cycle. Final rptr_gray=5'h18 and rd_empty=1.
- Backpressure: the same 16 words with rready toggling 1,0,1,0 -> no word lost or duplicated, and rdata stable while rvalid && !rready.
- Wrap: three successive 16-word batches -> rd_addr wraps 15->0 each batch and rbin MSB toggles. Empty is asserted only after each batch drains, with rdata correct across the wrap.
- Level/almost-empty: wq2 equivalent of 5 words, rready=0 -> one pop into the output register, then rd_level=4 and rd_almost_empty=0. Drain to level 2 -> rd_almost_empty=1.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared pointer helpers for both sides of the asynchronous FIFO.
// The functions work on a fixed 32-bit container. Callers zero-extend
// their pointer into it and truncate the result back to pointer width.
package fifo_pkg;

    localparam int GRAY_W = 32;

    // Binary to reflected Gray code.
    function automatic logic [GRAY_W-1:0] bin2gray(input logic [GRAY_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Gray to binary. Each binary bit is the XOR of all Gray bits at or above it.
    // Zero-extension does not change the result, so one width serves all pointers.
    function automatic logic [GRAY_W-1:0] gray2bin(input logic [GRAY_W-1:0] g);
        logic [GRAY_W-1:0] b;
        b = '0;
        for (int i = 0; i < GRAY_W; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a Gray-coded pointer that crosses clock domains.
// The write side uses this same block for the read pointer.
module sync_2ff #(
    parameter int WIDTH = 5
) (
    input  logic             rd_clk,
    input  logic             rd_rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage1_q;
    logic [WIDTH-1:0] stage2_q;

    // The first stage may go metastable. Only the second stage is used downstream.
    always_ff @(posedge rd_clk) begin
        if (!rd_rst_n) begin
            stage1_q <= '0;
            stage2_q <= '0;
        end else begin
            stage1_q <= d;
            stage2_q <= stage1_q;
        end
    end

    assign q = stage2_q;

endmodule

// File: rtl/fifo_read_ctrl.sv
// Read-domain controller for the asynchronous FIFO. It owns the read pointer
// and computes empty, almost-empty and fill level from the synchronized write
// pointer. It feeds a first-word-fall-through valid/ready output register.
module fifo_read_ctrl
    import fifo_pkg::*;
#(
    parameter int DATASIZE      = 8,
    parameter int ADDRSIZE      = 4,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                rd_clk,
    input  logic                rd_rst_n,
    input  logic [ADDRSIZE:0]   wptr_gray,
    input  logic [DATASIZE-1:0] mem_rdata,
    output logic [ADDRSIZE-1:0] rd_addr,
    output logic [ADDRSIZE:0]   rptr_gray,
    output logic                rd_empty,
    output logic                rd_almost_empty,
    output logic [ADDRSIZE:0]   rd_level,
    output logic [DATASIZE-1:0] rdata,
    output logic                rvalid,
    input  logic                rready
);

    localparam int PTRW = ADDRSIZE + 1;

    logic [PTRW-1:0]     rbin_q,     rbin_d;
    logic [PTRW-1:0]     rptrGray_q, rptrGray_d;
    logic [PTRW-1:0]     level_q,    level_d;
    logic                empty_q,    empty_d;
    logic                aempty_q,   aempty_d;
    logic                rvalid_q,   rvalid_d;
    logic [DATASIZE-1:0] rdata_q,    rdata_d;
    logic [PTRW-1:0]     wq2;
    logic [PTRW-1:0]     wbinSync;
    logic                pop;

    sync_2ff #(
        .WIDTH (PTRW)
    ) uWptrSync (
        .rd_clk   (rd_clk),
        .rd_rst_n (rd_rst_n),
        .d        (wptr_gray),
        .q        (wq2)
    );

    // A word leaves memory when one is available and the output register is free
    // or is being drained this cycle. This allows one word per cycle when streaming.
    // Flags are computed from the post-pop pointer. The level therefore never
    // counts the word that now sits in the output register.
    always_comb begin
        pop        = !empty_q && (!rvalid_q || rready);
        rbin_d     = rbin_q + PTRW'(pop);
        rptrGray_d = PTRW'(bin2gray(GRAY_W'(rbin_d)));
        wbinSync   = PTRW'(gray2bin(GRAY_W'(wq2)));
        level_d    = wbinSync - rbin_d;
        empty_d    = (rptrGray_d == wq2);
        aempty_d   = (int'(level_d) <= AEMPTY_THRESH);
        rdata_d    = rdata_q;
        rvalid_d   = rvalid_q;
        if (pop) begin
            rdata_d  = mem_rdata;
            rvalid_d = 1'b1;
        end else if (rvalid_q && rready) begin
            rvalid_d = 1'b0;
        end
    end

    // Register all read-side state. Reset leaves the FIFO looking empty.
    always_ff @(posedge rd_clk) begin
        if (!rd_rst_n) begin
            rbin_q     <= '0;
            rptrGray_q <= '0;
            level_q    <= '0;
            empty_q    <= 1'b1;
            aempty_q   <= 1'b1;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            rbin_q     <= rbin_d;
            rptrGray_q <= rptrGray_d;
            level_q    <= level_d;
            empty_q    <= empty_d;
            aempty_q   <= aempty_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
        end
    end

    assign rd_addr         = rbin_q[ADDRSIZE-1:0];
    assign rptr_gray       = rptrGray_q;
    assign rd_empty        = empty_q;
    assign rd_almost_empty = aempty_q;
    assign rd_level        = level_q;
    assign rdata           = rdata_q;
    assign rvalid          = rvalid_q;

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Testbench for fifo_read_ctrl. The bench models the FIFO memory and the write
// side. It predicts every output from word counts: words written, and words
// taken from memory by the reader.
module tb_fifo_read_ctrl;

    logic       rd_clk = 1'b0;
    logic       rd_rst_n = 1'b0;
    logic [4:0] wptr_gray = '0;
    logic [7:0] mem_rdata;
    logic [3:0] rd_addr;
    logic [4:0] rptr_gray;
    logic       rd_empty;
    logic       rd_almost_empty;
    logic [4:0] rd_level;
    logic [7:0] rdata;
    logic       rvalid;
    logic       rready = 1'b0;

    logic [7:0] memModel [16];

    int compared   = 0;
    int mismatched = 0;

    int         wrCount;
    int         rdCount;
    int         wSeen1;
    int         wSeen2;
    int         mLevel;
    bit         mValid;
    bit         mEmpty;
    bit         mAe;
    logic [7:0] mData;

    fifo_read_ctrl #(
        .DATASIZE      (8),
        .ADDRSIZE      (4),
        .AEMPTY_THRESH (2)
    ) dut (
        .rd_clk          (rd_clk),
        .rd_rst_n        (rd_rst_n),
        .wptr_gray       (wptr_gray),
        .mem_rdata       (mem_rdata),
        .rd_addr         (rd_addr),
        .rptr_gray       (rptr_gray),
        .rd_empty        (rd_empty),
        .rd_almost_empty (rd_almost_empty),
        .rd_level        (rd_level),
        .rdata           (rdata),
        .rvalid          (rvalid),
        .rready          (rready)
    );

    // The memory reads combinationally at the address the reader drives.
    assign mem_rdata = memModel[rd_addr];

    // Free-running read clock with a 10-unit period.
    always #5 rd_clk = ~rd_clk;

    function automatic logic [4:0] gray5(input int v);
        logic [4:0] b;
        b = v[4:0];
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance the count-based model by one clock edge. The write count crosses
    // into the reader two edges late. Flags reflect the count after this edge's pop.
    task automatic modelStep();
        bit popNow;
        if (!rd_rst_n) begin
            rdCount = 0;
            mValid  = 1'b0;
            mData   = '0;
            wSeen1  = 0;
            wSeen2  = 0;
            mLevel  = 0;
            mEmpty  = 1'b1;
            mAe     = 1'b1;
        end else begin
            popNow = !mEmpty && (!mValid || rready);
            if (popNow) begin
                mData  = memModel[rdCount % 16];
                mValid = 1'b1;
                rdCount++;
            end else if (mValid && rready) begin
                mValid = 1'b0;
            end
            mLevel = (wSeen2 - (rdCount % 32) + 32) % 32;
            mEmpty = (mLevel == 0);
            mAe    = (mLevel <= 2);
            wSeen2 = wSeen1;
            wSeen1 = wrCount % 32;
        end
    endtask

    task automatic checkOutput();
        check("rd_empty",        rd_empty,        mEmpty);
        check("rd_almost_empty", rd_almost_empty, mAe);
        check("rd_level",        rd_level,        mLevel);
        check("rvalid",          rvalid,          mValid);
        check("rdata",           rdata,           mData);
        check("rptr_gray",       rptr_gray,       gray5(rdCount % 32));
        check("rd_addr",         rd_addr,         rdCount % 16);
    endtask

    task automatic applyStimulus(input bit rr);
        rready = rr;
        @(posedge rd_clk);
        modelStep();
        #1;
        checkOutput();
    endtask

    task automatic writeWord(input logic [7:0] d);
        memModel[wrCount % 16] = d;
        wrCount++;
        wptr_gray = gray5(wrCount % 32);
    endtask

    task automatic resetDut();
        rd_rst_n  = 1'b0;
        wrCount   = 0;
        wptr_gray = gray5(0);
        repeat (2) applyStimulus(1'b0);
        rd_rst_n  = 1'b1;
    endtask

    task automatic drain(input string tag);
        int c;
        c = 0;
        while (c < 100 && !(rdCount == wrCount && !mValid)) begin
            applyStimulus(1'($urandom_range(0, 1)));
            c++;
        end
        check(tag, (rdCount == wrCount && !mValid), 1);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) memModel[i] = 8'(8'h30 + i);
        wrCount = 0;
        rdCount = 0;
        wSeen1  = 0;
        wSeen2  = 0;
        mLevel  = 0;
        mValid  = 1'b0;
        mEmpty  = 1'b1;
        mAe     = 1'b1;
        mData   = '0;

        // Reset held with a non-zero write pointer, then synchronizer latency.
        rd_rst_n  = 1'b0;
        wrCount   = 2;
        wptr_gray = gray5(2);
        repeat (3) applyStimulus(1'b0);
        check("resetEmpty", rd_empty, 1);
        check("resetLevel", rd_level, 0);
        rd_rst_n = 1'b1;
        applyStimulus(1'b0);
        applyStimulus(1'b0);
        check("emptyBeforeEdge3", rd_empty, 1);
        applyStimulus(1'b0);
        check("emptyFallsEdge3", rd_empty, 0);
        applyStimulus(1'b0);
        check("rvalidEdge4", rvalid, 1);
        check("rdataEdge4", rdata, 8'h30);

        // Single word held under backpressure, then accepted.
        resetDut();
        writeWord(8'hA5);
        repeat (14) applyStimulus(1'b0);
        check("singleRdata", rdata, 8'hA5);
        check("singleValid", rvalid, 1);
        check("singleEmpty", rd_empty, 1);
        check("singleRptr", rptr_gray, 5'h01);
        applyStimulus(1'b1);
        check("singleAccepted", rvalid, 0);
        applyStimulus(1'b0);

        // Streaming 16 words at full throughput.
        resetDut();
        for (int i = 0; i < 16; i++) writeWord(8'(i));
        repeat (22) applyStimulus(1'b1);
        check("streamRptr", rptr_gray, 5'h18);
        check("streamEmpty", rd_empty, 1);
        check("streamValid", rvalid, 0);

        // Same 16 words with alternating ready.
        resetDut();
        for (int i = 0; i < 16; i++) writeWord(8'(i));
        for (int i = 0; i < 44; i++) applyStimulus(i % 2 == 0);
        drain("bpDrain");
        check("bpRptr", rptr_gray, 5'h18);

        // Three batches crossing the address and pointer-MSB wraps.
        for (int b = 0; b < 3; b++) begin
            for (int k = 0; k < 16; k++) writeWord(8'(8'h40 + b * 16 + k));
            drain("wrapDrain");
            check("wrapEmpty", rd_empty, 1);
            check("wrapAddr", rd_addr, 0);
        end

        // Level and almost-empty around the threshold.
        resetDut();
        for (int i = 0; i < 5; i++) writeWord(8'(8'hC0 + i));
        repeat (6) applyStimulus(1'b0);
        check("level4", rd_level, 4);
        check("aeAt4", rd_almost_empty, 0);
        applyStimulus(1'b1);
        applyStimulus(1'b1);
        check("level2", rd_level, 2);
        check("aeAt2", rd_almost_empty, 1);
        applyStimulus(1'b0);
        check("aeHeld", rd_almost_empty, 1);

        // Random writes and random consumer readiness.
        resetDut();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) != 0 && (wrCount - rdCount) < 16) writeWord(8'($urandom));
            applyStimulus($urandom_range(0, 3) != 0);
        end
        drain("randomDrain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
